// File: rtl/wb_merge.sv
// wb_merge: write-back merge stage in front of the single regfile write port.
// The pipeline write-back always wins the port. Secondary (mul/div) results are
// queued in a small FIFO and drained into idle pipeline slots.
// pend_mask flags the destination registers of queued secondary results.
// Optional feature macro: WB_MERGE_STARVE_EN builds the starvation counter
// that drives stall_req. Without it, stall_req is tied low.
module wb_merge #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_we,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_wa,
    input  logic [31:0] s_wd,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] pend_mask,
    output logic        stall_req
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("wb_merge: DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("wb_merge: STARVE_LIMIT must be in 1..255");
    end

    logic [4:0]  mem_wa [DEPTH];
    logic [31:0] mem_wd [DEPTH];
    logic [AW:0] wptr, rptr, wptr_n, rptr_n, occ_n;
    logic        empty, push, pop, full_n;
    logic [31:0] pend_n;
    logic [AW-1:0] idx;
    logic [4:0]  wa_i;

    // Handshake, arbitration and next pointer/occupancy/mask state
    always_comb begin
        empty  = (wptr == rptr);
        push   = s_valid && s_ready && (s_wa != '0);
        pop    = !p_we && !empty;
        wptr_n = push ? wptr + 1'b1 : wptr;
        rptr_n = pop  ? rptr + 1'b1 : rptr;
        full_n = (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
        occ_n  = wptr_n - rptr_n;
        pend_n = '0;
        idx    = '0;
        wa_i   = '0;
        // Mask is rebuilt from the post-update queue contents, with a same-cycle push
        // seen directly from s_wa. This keeps it registered alongside the FIFO.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx  = rptr_n[AW-1:0] + AW'(i);
            wa_i = (push && idx == wptr[AW-1:0]) ? s_wa : mem_wa[idx];
            if (i < 32'(occ_n)) begin
                pend_n[wa_i] = 1'b1;
            end
        end
        pend_n[0] = 1'b0;
    end

    // FIFO storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_wa[wptr[AW-1:0]] <= s_wa;
            mem_wd[wptr[AW-1:0]] <= s_wd;
        end
    end

    // Pointers, registered status outputs and the regfile write port
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            s_ready   <= 1'b0;
            pend_mask <= '0;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
        end else begin
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            s_ready   <= !full_n;
            pend_mask <= pend_n;
            if (p_we) begin
                rf_we <= 1'b1;
                rf_wa <= p_wa;
                rf_wd <= p_wd;
            end else if (pop) begin
                rf_we <= 1'b1;
                rf_wa <= mem_wa[rptr[AW-1:0]];
                rf_wd <= mem_wd[rptr[AW-1:0]];
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

`ifdef WB_MERGE_STARVE_EN
    logic [7:0] cnt, cnt_n;

    // Count consecutive posedges where a queued result is blocked by the pipeline
    always_comb begin
        cnt_n = cnt;
        if (pop || empty) begin
            cnt_n = '0;
        end else if (p_we && cnt != 8'(STARVE_LIMIT)) begin
            cnt_n = cnt + 8'd1;
        end
    end

    // Starvation counter register and stall request (released by the next pop)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            stall_req <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (pop) begin
                stall_req <= 1'b0;
            end else if (cnt_n == 8'(STARVE_LIMIT)) begin
                stall_req <= 1'b1;
            end
        end
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: doc/wb_merge.md
# wb_merge

Write-back merge stage sitting directly upstream of the register file's single write port. It combines the in-order pipeline write-back stream with results from a long-latency secondary producer (mul/div unit), which arrive through a valid/ready handshake. Secondary results are buffered in a small FIFO and drained into idle pipeline write slots. The block exports a pending-register mask for the hazard unit and, optionally, a stall request that prevents starvation of the secondary results.

## Interface
- DEPTH, 4: secondary FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8: consecutive blocked cycles before stall_req asserts (1..255)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- p_we  in  1  pipeline write-back valid
- p_wa  in  5  pipeline destination register
- p_wd  in  32  pipeline write data
- s_valid  in  1  secondary result valid
- s_ready  out  1  secondary accept; registered, equals !full
- s_wa  in  5  secondary destination register
- s_wd  in  32  secondary write data
- rf_we  out  1  regfile write enable; registered
- rf_wa  out  5  regfile write address; registered
- rf_wd  out  32  regfile write data; registered
- pend_mask  out  32  bit r set while a queued secondary write to r exists; registered
- stall_req  out  1  request that the pipeline hold p_we=0; registered

## Operation
- A secondary transfer occurs on a posedge with s_valid && s_ready.
  - If s_wa==0, the result is accepted and discarded: not enqueued, no mask bit set.
  - Otherwise {s_wa, s_wd} is pushed at the FIFO tail.
- Arbitration at each posedge:
  - If p_we=1, the pipeline wins: rf_we←1, rf_wa←p_wa, rf_wd←p_wd.
  - Otherwise, if the FIFO is non-empty, the head is popped: rf_we←1, rf_wa/rf_wd←head.
  - Otherwise rf_we←0, and rf_wa/rf_wd hold their values.
- A pipeline write with p_wa==0 is forwarded unchanged; the regfile ignores it.
- A push and a pop in the same cycle are allowed. An entry pushed at posedge N is first eligible to pop at posedge N+1.
- pend_mask is the OR of one-hot(wa) over all valid FIFO entries. Bit 0 is always 0. Duplicate addresses in the queue keep the bit set until the last matching entry pops.
- No reordering or same-register conflict resolution is done here. The hazard unit uses pend_mask to stall readers and WAW producers.
- Pointers are log2(DEPTH) bits plus one wrap bit:
  - full = ptr MSBs differ and lower bits equal;
  - empty = pointers equal.
- Pointers wrap modulo 2·DEPTH.
- Reset clears:
  - outputs: rf_we=0, rf_wa=0, rf_wd=0, pend_mask=0, stall_req=0, s_ready=0;
  - state: FIFO empty, starvation counter 0.
- Reset mid-operation discards all queued entries.
- s_ready rises in the first cycle after rst deasserts.

## Timing
- Pipeline latency is 1 cycle: p_we sampled at posedge N gives rf_we=1 during cycle N+1. The regfile commits it at the negedge inside cycle N+1.
- Secondary latency:
  - minimum 2 cycles, push at N, pop at N+1, rf_we in cycle N+2;
  - otherwise bounded by queue occupancy and pipeline idle slots.
- s_ready is computed from post-update occupancy, so it falls in the cycle after the push that fills the FIFO.
- A pop in that same cycle keeps s_ready=1.
- pend_mask updates in the same cycle as the push or pop that changes it, i.e. registered alongside the FIFO.
- stall_req, when enabled:
  - an 8-bit counter increments on each posedge where the FIFO is non-empty and p_we=1;
  - it clears on any pop or when the FIFO is empty;
  - stall_req←1 at the posedge where the counter reaches STARVE_LIMIT;
  - stall_req←0 at the posedge of the next pop.
- If the pipeline still drives p_we=1 while stall_req=1, the pipeline still wins and the counter saturates. This case is illegal upstream but not fatal.

## Configuration
- WB_MERGE_STARVE_EN defined: starvation counter and stall_req behave as described above.
- WB_MERGE_STARVE_EN undefined:
  - no counter is built and stall_req is tied to 0;
  - secondary results drain only in idle pipeline slots, and starvation is the system's responsibility.

## Test plan
- Reset then idle:
  - all outputs 0 during rst, s_ready=1 one cycle after release;
  - p_we=1, p_wa=5, p_wd=0xDEADBEEF at posedge N → rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in cycle N+1 only.
- Collision: p_we=1 (wa=3) and FIFO holding {wa=7, 0x11} at the same posedge → rf_wa=3 first, then rf_wa=7 in the following idle cycle; pend_mask=0x80 until the pop.
- Fill and backpressure with DEPTH=4, p_we held 1:
  - four pushes (wa 8..11) → s_ready=0 and pend_mask=0x00000F00;
  - release p_we → drains in order 8, 9, 10, 11, with s_ready=1 again after the first pop.
- Zero register: s_valid with s_wa=0 accepted, pend_mask stays 0, no rf_we is ever generated.
- Starvation (macro defined, STARVE_LIMIT=8): one queued entry with p_we=1 continuously → stall_req=1 after the 8th blocked posedge; p_we dropped → pop next cycle and stall_req=0. With the macro undefined, stall_req stays 0 throughout.
- Reset mid-queue: 3 entries queued, rst pulsed 1 cycle → pend_mask=0 and no rf_we from the discarded entries afterward.
